// File: rtl/led_driver_pkg.sv
// Shared register map, field layouts and reset values for the LED driver.
package led_driver_pkg;

  localparam int ADDR_BITS = 3;
  localparam int DATA_BITS = 8;
  localparam int PWM_BITS  = 8;
  localparam int NUM_REGS  = 2 ** ADDR_BITS;
  localparam int NUM_LEDS  = 4;

  typedef enum logic [ADDR_BITS-1:0] {
    REG_MODE    = 3'd0,
    REG_PWM0    = 3'd1,
    REG_PWM1    = 3'd2,
    REG_PWM2    = 3'd3,
    REG_PWM3    = 3'd4,
    REG_GRPPWM  = 3'd5,
    REG_GRPFREQ = 3'd6,
    REG_LEDOUT  = 3'd7
  } reg_enum_t;

  typedef struct packed {
    logic [2:0] rsvd_hi;
    logic       sleep;
    logic       dim_blink;
    logic       invert;
    logic [1:0] rsvd_lo;
  } reg_mode_t;

  typedef enum logic [1:0] {
    LED_OFF        = 2'd0,
    LED_ON         = 2'd1,
    LED_INDIVIDUAL = 2'd2,
    LED_GROUP      = 2'd3
  } led_out_enum_t;

  typedef struct packed {
    led_out_enum_t led3;
    led_out_enum_t led2;
    led_out_enum_t led1;
    led_out_enum_t led0;
  } reg_led_out_t;

  localparam logic [DATA_BITS-1:0] REG_MODE_RST    = 8'h00;
  localparam logic [DATA_BITS-1:0] REG_PWM_RST     = 8'h00;
  localparam logic [DATA_BITS-1:0] REG_GRPPWM_RST  = 8'hFF;
  localparam logic [DATA_BITS-1:0] REG_GRPFREQ_RST = 8'h00;
  localparam logic [DATA_BITS-1:0] REG_LEDOUT_RST  = 8'h00;

  function automatic logic [DATA_BITS-1:0] reg_reset_value(input reg_enum_t r);
    case (r)
      REG_MODE:    return REG_MODE_RST;
      REG_GRPPWM:  return REG_GRPPWM_RST;
      REG_GRPFREQ: return REG_GRPFREQ_RST;
      REG_LEDOUT:  return REG_LEDOUT_RST;
      default:     return REG_PWM_RST;
    endcase
  endfunction

endpackage

// File: rtl/led_pwm_prescaler.sv
// Free-running divider: one-clock tick every DIV clocks, restartable by a synchronous clear.
module led_pwm_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_BITS = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DIV - 1);

  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clear) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED-side register file plus individual / group-dim / group-blink PWM sequencing for LED0..3.
module led_pwm_ctrl
  import led_driver_pkg::*;
#(
  parameter int IND_PRESCALE   = 4,
  parameter int GRP_PRESCALE   = 32,
  parameter int BLINK_PRESCALE = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sleep,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 r_en,
  input  logic                 w_en,
  inout  wire  [DATA_BITS-1:0] data,
  output logic [NUM_LEDS-1:0]  led_out
);

  logic [DATA_BITS-1:0] regs [NUM_REGS];
  logic [PWM_BITS-1:0]  pwm_live [NUM_LEDS];
  logic [PWM_BITS-1:0]  pwm_sh [NUM_LEDS];
  logic [PWM_BITS-1:0]  grppwm_sh, grpfreq_sh;
  logic [PWM_BITS-1:0]  ind_cnt, grp_cnt, phase_cnt, tick_div;
  logic                 asleep, asleep_q, dim_blink_q, mode_switch;
  logic                 ind_tick, grp_tick, blink_tick;
  logic [NUM_LEDS-1:0]  ind_on, lit;
  logic                 grp_on;
  reg_mode_t            mode;
  reg_led_out_t         ledout;
  led_out_enum_t        led_mode [NUM_LEDS];
  logic                 unused_mode_bits;

  assign mode             = reg_mode_t'(regs[REG_MODE]);
  assign ledout           = reg_led_out_t'(regs[REG_LEDOUT]);
  assign led_mode         = '{ledout.led0, ledout.led1, ledout.led2, ledout.led3};
  assign pwm_live         = '{regs[REG_PWM0], regs[REG_PWM1], regs[REG_PWM2], regs[REG_PWM3]};
  assign unused_mode_bits = ^{mode.rsvd_hi, mode.rsvd_lo};

  assign asleep      = sleep | mode.sleep;
  assign mode_switch = mode.dim_blink != dim_blink_q;

  // Only the divider of the active group mode runs; a mode change restarts both.
  led_pwm_prescaler #(.DIV(IND_PRESCALE)) u_ind_pre (
    .clk(clk), .reset(reset), .clear(asleep), .tick(ind_tick)
  );
  led_pwm_prescaler #(.DIV(GRP_PRESCALE)) u_grp_pre (
    .clk(clk), .reset(reset), .clear(asleep | mode_switch | mode.dim_blink), .tick(grp_tick)
  );
  led_pwm_prescaler #(.DIV(BLINK_PRESCALE)) u_blink_pre (
    .clk(clk), .reset(reset), .clear(asleep | mode_switch | !mode.dim_blink), .tick(blink_tick)
  );

  // A read with a simultaneous write leaves the bus to the writer.
  assign data = (r_en && !w_en) ? regs[addr] : {DATA_BITS{1'bz}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reg_reset_value(reg_enum_t'(ADDR_BITS'(i)));
      for (int n = 0; n < NUM_LEDS; n++) pwm_sh[n] <= '0;
      grppwm_sh   <= '0;
      grpfreq_sh  <= '0;
      ind_cnt     <= '0;
      grp_cnt     <= '0;
      phase_cnt   <= '0;
      tick_div    <= '0;
      asleep_q    <= 1'b0;
      dim_blink_q <= 1'b0;
      led_out     <= '0;
    end else begin
      if (w_en) regs[addr] <= data;
      asleep_q    <= asleep;
      dim_blink_q <= mode.dim_blink;
      led_out     <= mode.invert ? ~lit : lit;

      // Shadows follow the live registers while asleep so wake-up starts from fresh values.
      if (asleep) begin
        ind_cnt    <= '0;
        grp_cnt    <= '0;
        phase_cnt  <= '0;
        tick_div   <= '0;
        for (int n = 0; n < NUM_LEDS; n++) pwm_sh[n] <= pwm_live[n];
        grppwm_sh  <= regs[REG_GRPPWM];
        grpfreq_sh <= regs[REG_GRPFREQ];
      end else begin
        if (ind_tick) begin
          ind_cnt <= ind_cnt + 8'd1;
          if (ind_cnt == 8'hFF)
            for (int n = 0; n < NUM_LEDS; n++) pwm_sh[n] <= pwm_live[n];
        end

        if (mode_switch) begin
          grp_cnt    <= '0;
          phase_cnt  <= '0;
          tick_div   <= '0;
          grppwm_sh  <= regs[REG_GRPPWM];
          grpfreq_sh <= regs[REG_GRPFREQ];
        end else if (!mode.dim_blink) begin
          if (grp_tick) begin
            grp_cnt <= grp_cnt + 8'd1;
            if (grp_cnt == 8'hFF) begin
              grppwm_sh  <= regs[REG_GRPPWM];
              grpfreq_sh <= regs[REG_GRPFREQ];
            end
          end
        end else if (blink_tick) begin
          if (tick_div == grpfreq_sh) begin
            tick_div  <= '0;
            phase_cnt <= phase_cnt + 8'd1;
            if (phase_cnt == 8'hFF) begin
              grppwm_sh  <= regs[REG_GRPPWM];
              grpfreq_sh <= regs[REG_GRPFREQ];
            end
          end else begin
            tick_div <= tick_div + 8'd1;
          end
        end

        if (asleep_q) begin
          for (int n = 0; n < NUM_LEDS; n++) pwm_sh[n] <= pwm_live[n];
          grppwm_sh  <= regs[REG_GRPPWM];
          grpfreq_sh <= regs[REG_GRPFREQ];
        end
      end
    end
  end

  assign grp_on = mode.dim_blink ? (phase_cnt < grppwm_sh) : (grp_cnt < grppwm_sh);

  always_comb begin
    ind_on = '0;
    lit    = '0;
    for (int n = 0; n < NUM_LEDS; n++) begin
      ind_on[n] = ind_cnt < pwm_sh[n];
      case (led_mode[n])
        LED_OFF:        lit[n] = 1'b0;
        LED_ON:         lit[n] = 1'b1;
        LED_INDIVIDUAL: lit[n] = ind_on[n];
        default:        lit[n] = ind_on[n] & grp_on;
      endcase
    end
    if (asleep) lit = '0;
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: an elapsed-time reference model predicts every led_out and bus read.
module tb_led_pwm_ctrl;
  import led_driver_pkg::*;

  localparam int IND_P   = 1;
  localparam int GRP_P   = 4;
  localparam int BLINK_P = 2;

  logic       clk = 1'b0;
  logic       reset, sleep, r_en, w_en;
  logic [2:0] addr;
  logic [7:0] tb_data;
  wire  [7:0] data;
  logic [3:0] led_out;

  int tests = 0;
  int failures = 0;

  logic [3:0] led_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] m_regs [8];

  assign data = w_en ? tb_data : 8'bz;
  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .IND_PRESCALE(IND_P), .GRP_PRESCALE(GRP_P), .BLINK_PRESCALE(BLINK_P)
  ) dut (
    .clk(clk), .reset(reset), .sleep(sleep), .addr(addr), .r_en(r_en),
    .w_en(w_en), .data(data), .led_out(led_out)
  );

  function automatic logic [7:0] rst_value(input int i);
    return (i == 5) ? 8'hFF : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One bus cycle: 0 idle, 1 write, 2 read, 3 read+write contention.
  task automatic applyStimulus(input int kind, input logic [2:0] a, input logic [7:0] d);
    addr    = a;
    tb_data = d;
    w_en    = (kind == 1 || kind == 3);
    r_en    = (kind == 2 || kind == 3);
    if (kind == 2) rd_q.push_back(m_regs[a]);
    else if (kind == 3) rd_q.push_back(d);
    @(posedge clk); #2;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic countLed(input int b, input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += int'(led_out[b]);
    end
    @(posedge clk); #2;
  endtask

  // Reference model: counters derived from clocks elapsed since the last restart.
  initial begin : ref_model
    int         n_ind, n_grp, step;
    logic [7:0] ind_cnt, cnt_dim, cnt_phase, gsh_pwm, gsh_freq;
    logic [7:0] ind_sh [4];
    logic       prev_asleep, prev_dim, asleep, dim, ind_on, grp_on;
    logic [3:0] lit;
    forever begin
      @(posedge clk);
      if (!reset) begin
        led_q.push_back(4'b0000);
        for (int i = 0; i < 8; i++) m_regs[i] = rst_value(i);
        for (int n = 0; n < 4; n++) ind_sh[n] = 8'h00;
        n_ind = 0; n_grp = 0; ind_cnt = 0; cnt_dim = 0; cnt_phase = 0;
        gsh_pwm = 0; gsh_freq = 0; prev_asleep = 0; prev_dim = 0;
      end else begin
        asleep = sleep | m_regs[0][4];
        dim    = m_regs[0][3];
        grp_on = dim ? (cnt_phase < gsh_pwm) : (cnt_dim < gsh_pwm);
        lit    = 4'b0000;
        for (int n = 0; n < 4; n++) begin
          ind_on = ind_cnt < ind_sh[n];
          case (m_regs[7][2*n +: 2])
            2'd0: lit[n] = 1'b0;
            2'd1: lit[n] = 1'b1;
            2'd2: lit[n] = ind_on;
            default: lit[n] = ind_on & grp_on;
          endcase
        end
        if (asleep) lit = 4'b0000;
        led_q.push_back(m_regs[0][2] ? ~lit : lit);

        if (asleep) begin
          n_ind = 0; n_grp = 0; ind_cnt = 0; cnt_dim = 0; cnt_phase = 0;
          for (int n = 0; n < 4; n++) ind_sh[n] = m_regs[1 + n];
          gsh_pwm = m_regs[5]; gsh_freq = m_regs[6];
        end else begin
          n_ind++;
          ind_cnt = 8'((n_ind / IND_P) % 256);
          if (n_ind % (256 * IND_P) == 0)
            for (int n = 0; n < 4; n++) ind_sh[n] = m_regs[1 + n];
          if (dim != prev_dim) begin
            n_grp = 0; cnt_dim = 0; cnt_phase = 0;
            gsh_pwm = m_regs[5]; gsh_freq = m_regs[6];
          end else begin
            n_grp++;
            step = dim ? BLINK_P * (int'(gsh_freq) + 1) : GRP_P;
            if (n_grp == 256 * step) begin
              n_grp = 0;
              gsh_pwm = m_regs[5]; gsh_freq = m_regs[6];
            end
            if (dim) cnt_phase = 8'(n_grp / step);
            else cnt_dim = 8'(n_grp / step);
          end
          if (prev_asleep) begin
            for (int n = 0; n < 4; n++) ind_sh[n] = m_regs[1 + n];
            gsh_pwm = m_regs[5]; gsh_freq = m_regs[6];
          end
        end
        prev_asleep = asleep;
        prev_dim    = dim;
        if (w_en) m_regs[addr] = data;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (led_q.size() > 0) checkOutput("led_out", int'(led_out), int'(led_q.pop_front()));
      else begin
        tests++; failures++;
        $display("[TB] FAIL led_q: no expected value for led_out=%0d at %0t", led_out, $time);
      end
      if (r_en) begin
        if (rd_q.size() > 0) checkOutput("bus_data", int'(data), int'(rd_q.pop_front()));
        else begin
          tests++; failures++;
          $display("[TB] FAIL rd_q: no expected value for data=%0d at %0t", data, $time);
        end
      end
    end
  end

  initial begin : stimulus
    int c, r;
    reset = 1'b0; sleep = 1'b0; r_en = 1'b0; w_en = 1'b1;
    addr = REG_PWM0; tb_data = 8'hAA;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_led", int'(led_out), 0);
    reset = 1'b1; w_en = 1'b0;
    applyStimulus(2, REG_GRPPWM, 8'h00);
    applyStimulus(2, REG_PWM0, 8'h00);

    applyStimulus(1, REG_PWM0, 8'h40);
    applyStimulus(1, REG_LEDOUT, 8'h02);
    idle(600);
    countLed(0, 256, c);
    checkOutput("ind_duty", c, 64);

    applyStimulus(1, REG_PWM1, 8'hFF);
    applyStimulus(1, REG_GRPPWM, 8'h80);
    applyStimulus(1, REG_LEDOUT, 8'h0C);
    idle(2100);
    countLed(1, 1024, c);
    checkOutput("grp_dim_duty", c, 510);

    applyStimulus(1, REG_GRPFREQ, 8'h01);
    applyStimulus(1, REG_MODE, 8'h08);
    idle(1100);
    countLed(1, 1024, c);
    checkOutput("blink_duty", c, 510);

    applyStimulus(1, REG_MODE, 8'h04);
    applyStimulus(1, REG_LEDOUT, 8'h55);
    idle(1);
    checkOutput("invert_on", int'(led_out), 0);
    applyStimulus(1, REG_LEDOUT, 8'h00);
    idle(1);
    checkOutput("invert_off", int'(led_out), 15);

    applyStimulus(1, REG_MODE, 8'h00);
    applyStimulus(1, REG_LEDOUT, 8'h55);
    idle(2);
    sleep = 1'b1;
    idle(1);
    checkOutput("sleep_led", int'(led_out), 0);
    applyStimulus(1, REG_LEDOUT, 8'h02);
    applyStimulus(1, REG_PWM3, 8'h77);
    applyStimulus(2, REG_PWM3, 8'h00);
    idle(5);
    sleep = 1'b0;
    idle(600);

    applyStimulus(3, REG_PWM2, 8'h33);
    idle(2);
    applyStimulus(2, REG_PWM2, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(99));
      if (r < 2) sleep = ~sleep;
      if (r == 99) begin
        reset = 1'b0;
        applyStimulus(1, 3'($urandom_range(7)), 8'($urandom));
        reset = 1'b1;
      end else if (r < 40) applyStimulus(0, 3'd0, 8'h00);
      else if (r < 70) applyStimulus(1, 3'($urandom_range(7)), 8'($urandom));
      else if (r < 95) applyStimulus(2, 3'($urandom_range(7)), 8'h00);
      else applyStimulus(3, 3'($urandom_range(7)), 8'($urandom));
    end
    sleep = 1'b0;
    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
